// File: rtl/vc_queue_rr_sched.sv
// Round-robin merge of several val/rdy producers into one shared queue input,
// with an optional burst lock that keeps the grant on one requester.
module vc_queue_rr_sched #(
   parameter int p_nreqs     = 4,
   parameter int p_msg_nbits = 32,
   parameter int p_max_burst = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [p_nreqs-1:0]               in_val,
   output logic [p_nreqs-1:0]               in_rdy,
   input  logic [p_nreqs*p_msg_nbits-1:0]   in_msg,
   output logic                             out_val,
   input  logic                             out_rdy,
   output logic [p_msg_nbits-1:0]           out_msg,
   output logic [$clog2(p_nreqs)-1:0]       out_src,
   output logic [p_nreqs-1:0]               grant,
   output logic                             locked
);

   localparam int PW = $clog2(p_nreqs);
   localparam int BW = $clog2(p_max_burst + 1);
   localparam logic [PW-1:0] LastIdx  = PW'(p_nreqs - 1);
   localparam logic [BW-1:0] MaxBurst = BW'(p_max_burst);

   logic [PW-1:0] prio_ptr_q, prio_ptr_d;
   logic [PW-1:0] owner_q, owner_d;
   logic          lock_q, lock_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;

   logic          found;
   logic [PW-1:0] sel;
   logic [PW-1:0] cand;
   logic          xfer;
   logic [BW-1:0] n_burst;

   // Explicit wrap compare so non-power-of-2 requester counts stay in range.
   function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
      if (v == LastIdx) return '0;
      return v + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_ptr_q  <= '0;
         owner_q     <= '0;
         lock_q      <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         prio_ptr_q  <= prio_ptr_d;
         owner_q     <= owner_d;
         lock_q      <= lock_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // A live lock overrides the round-robin scan starting at prio_ptr.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = prio_ptr_q;
      if (lock_q && in_val[owner_q]) begin
         found = 1'b1;
         sel   = owner_q;
      end
      for (int k = 0; k < p_nreqs; k++) begin
         if (!found && in_val[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
         cand = inc_wrap(cand);
      end
   end

   always_comb begin
      grant = '0;
      if (found) grant[sel] = 1'b1;
      out_val = found;
      out_src = found ? sel : '0;
      out_msg = found ? in_msg[int'(sel)*p_msg_nbits +: p_msg_nbits] : '0;
      in_rdy  = grant & {p_nreqs{out_rdy}};
      locked  = lock_q;
   end

   // Release of an idle owner is applied first so a same-cycle transfer wins.
   always_comb begin
      prio_ptr_d  = prio_ptr_q;
      owner_d     = owner_q;
      lock_d      = lock_q;
      burst_cnt_d = burst_cnt_q;
      xfer        = found & out_rdy;
      n_burst     = (lock_q && sel == owner_q) ? burst_cnt_q + BW'(1) : BW'(1);

      if (lock_q && !in_val[owner_q]) begin
         lock_d      = 1'b0;
         burst_cnt_d = '0;
         prio_ptr_d  = inc_wrap(owner_q);
      end

      if (xfer) begin
         if (n_burst == MaxBurst) begin
            lock_d      = 1'b0;
            burst_cnt_d = '0;
            prio_ptr_d  = inc_wrap(sel);
         end else begin
            lock_d      = 1'b1;
            owner_d     = sel;
            burst_cnt_d = n_burst;
         end
      end
   end

endmodule
